alpha_trim_sort_ctrl: RTL and testbench



---
 rtl/alpha_filter_pkg.sv | 33 +++
 rtl/trim_accumulator.sv | 75 +++++++
 rtl/alpha_trim_sort_ctrl.sv | 131 +++++++++++++
 tb/tb_alpha_trim_sort_ctrl.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_filter_pkg.sv
// Shared types and constants for the alpha-trimmed mean filter controller.
package alpha_filter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SORT,
        ST_WAIT,
        ST_GRAB,
        ST_ACC,
        ST_OUT
    } state_t;

    // Default geometry of the filter window
    localparam int DN_DEF    = 25;
    localparam int DW_DEF    = 8;
    localparam int ALPHA_DEF = 4;
    localparam int DW_SEQ    = $clog2(DN_DEF);
    localparam int SUM_W     = DW_DEF + $clog2(DN_DEF);

    // Number of samples kept after trimming ALPHA from each end
    function automatic int f_nkeep(input int dn, input int alpha);
        return dn - 2 * alpha;
    endfunction

    // Q16 reciprocal of the kept-sample count, rounded to nearest
    function automatic int f_recip(input int nkeep);
        return (65536 + nkeep / 2) / nkeep;
    endfunction

    localparam int NKEEP = f_nkeep(DN_DEF, ALPHA_DEF);
    localparam int RECIP = f_recip(NKEEP);

endpackage

// File: rtl/trim_accumulator.sv
// Walks the kept ranks of a sorted window, sums the selected samples and
// produces the rounded mean on the final add.
module trim_accumulator
    import alpha_filter_pkg::*;
#(
    parameter int DN     = 25,
    parameter int DW     = 8,
    parameter int DW_SEQ = $clog2(DN),
    parameter int ALPHA  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic                      i_step,
    input  logic [DW*DN-1:0]          i_data,
    input  logic [DW_SEQ*DN-1:0]      i_seq,
    output logic                      o_last,
    output logic [DW+$clog2(DN)-1:0]  o_sum,
    output logic [DW-1:0]             o_mean
);

    localparam int              NK   = f_nkeep(DN, ALPHA);
    localparam int              SW   = DW + $clog2(DN);
    localparam int              RW   = 17;
    localparam int              PW   = SW + RW + 1;
    localparam logic [RW-1:0]   RC   = RW'(f_recip(NK));
    localparam int              LAST = DN - 1 - ALPHA;

    logic [DW_SEQ*DN-1:0] r_seq;
    logic [DW_SEQ-1:0]    r_rank;
    logic [SW-1:0]        r_acc;
    logic [DW_SEQ-1:0]    w_idx;
    logic [DW-1:0]        w_sample;
    logic [SW-1:0]        w_acc_nxt;
    logic [PW-1:0]        w_prod;

    assign w_idx     = r_seq[r_rank*DW_SEQ +: DW_SEQ];
    assign o_last    = (r_rank == DW_SEQ'(LAST));
    assign w_acc_nxt = r_acc + SW'(w_sample);
    assign w_prod    = PW'(w_acc_nxt) * PW'(RC) + PW'(32768);

    // Select the sample whose original index sits at the current rank; unknown indices read as zero
    always_comb begin
        w_sample = '0;
        for (int k = 0; k < DN; k++) begin
            if (w_idx == DW_SEQ'(k)) begin
                w_sample = i_data[k*DW +: DW];
            end
        end
    end

    // Rank map capture and running sum; these hold data only and are re-initialised on every start
    always_ff @(posedge clk) begin
        if (i_start) begin
            r_seq  <= i_seq;
            r_acc  <= '0;
            r_rank <= DW_SEQ'(ALPHA);
        end else if (i_step) begin
            r_acc  <= w_acc_nxt;
            r_rank <= r_rank + 1'b1;
        end
    end

    // Result registers, loaded with the final sum and its rounded mean on the last add
    always_ff @(posedge clk) begin
        if (rst) begin
            o_sum  <= '0;
            o_mean <= '0;
        end else if (i_step && o_last) begin
            o_sum  <= w_acc_nxt;
            o_mean <= w_prod[16 +: DW];
        end
    end

endmodule

// File: rtl/alpha_trim_sort_ctrl.sv
// Sequencer for the parallel rank sorter: accepts a window, starts the sorter,
// waits (bounded) for completion, then accumulates the trimmed samples.
module alpha_trim_sort_ctrl
    import alpha_filter_pkg::*;
#(
    parameter int DN      = 25,
    parameter int DW      = 8,
    parameter int DW_SEQ  = $clog2(DN),
    parameter int ALPHA   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW*DN-1:0]          in_window,
    output logic                      sort_sig,
    output logic [DW*DN-1:0]          data_unsort,
    input  logic [DW_SEQ*DN-1:0]      sequence_sorted,
    input  logic                      sort_finish,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DW+$clog2(DN)-1:0]  out_sum,
    output logic [DW-1:0]             out_mean,
    output logic                      busy,
    output logic                      timeout_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_wait_cnt;
    logic [DW*DN-1:0] r_window;
    logic             r_timeout_err;
    logic             w_grab;
    logic             w_step;
    logic             w_timeout;
    logic             w_last;

    assign in_ready    = (r_state == ST_IDLE);
    assign sort_sig    = (r_state == ST_SORT);
    assign out_valid   = (r_state == ST_OUT);
    assign busy        = (r_state != ST_IDLE);
    assign data_unsort = r_window;
    assign timeout_err = r_timeout_err;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and datapath strobes
    always_comb begin
        w_state_nxt = r_state;
        w_grab      = 1'b0;
        w_step      = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nxt = ST_SORT;
            ST_SORT: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (sort_finish) begin
                    w_state_nxt = ST_GRAB;
                end else if (r_wait_cnt == TW'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRAB: begin
                w_grab      = 1'b1;
                w_state_nxt = ST_ACC;
            end
            ST_ACC: begin
                w_step = 1'b1;
                if (w_last) w_state_nxt = ST_OUT;
            end
            ST_OUT:  if (out_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Wait counter: cleared on sorter start, counts WAIT cycles without a finish pulse
    always_ff @(posedge clk) begin
        if (rst || r_state == ST_SORT) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT && !sort_finish) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Sticky timeout flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
        end
    end

    // Window latch, held stable for the sorter until the controller is idle again
    always_ff @(posedge clk) begin
        if (rst) begin
            r_window <= '0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_window <= in_window;
        end
    end

    trim_accumulator #(
        .DN     (DN),
        .DW     (DW),
        .DW_SEQ (DW_SEQ),
        .ALPHA  (ALPHA)
    ) u_trim_acc (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_grab),
        .i_step  (w_step),
        .i_data  (r_window),
        .i_seq   (sequence_sorted),
        .o_last  (w_last),
        .o_sum   (out_sum),
        .o_mean  (out_mean)
    );

endmodule

// File: tb/tb_alpha_trim_sort_ctrl.sv
// Bench for alpha_trim_sort_ctrl with a behavioural rank-sorter model.
module tb_alpha_trim_sort_ctrl;

    localparam int DN      = 25;
    localparam int DW      = 8;
    localparam int DW_SEQ  = $clog2(DN);
    localparam int ALPHA   = 4;
    localparam int TIMEOUT = 15;
    localparam int NK      = DN - 2 * ALPHA;
    localparam int SW      = DW + $clog2(DN);

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [DW*DN-1:0]     in_window;
    logic                 sort_sig;
    logic [DW*DN-1:0]     data_unsort;
    logic [DW_SEQ*DN-1:0] sequence_sorted;
    logic                 sort_finish;
    logic                 out_valid;
    logic                 out_ready;
    logic [SW-1:0]        out_sum;
    logic [DW-1:0]        out_mean;
    logic                 busy;
    logic                 timeout_err;

    logic sf_model;
    logic sf_stale;
    logic sorter_en;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_hs;
    int   last_acc;

    assign sort_finish = sf_model | sf_stale;

    alpha_trim_sort_ctrl #(
        .DN(DN), .DW(DW), .DW_SEQ(DW_SEQ), .ALPHA(ALPHA), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_window       (in_window),
        .sort_sig        (sort_sig),
        .data_unsort     (data_unsort),
        .sequence_sorted (sequence_sorted),
        .sort_finish     (sort_finish),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sum         (out_sum),
        .out_mean        (out_mean),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [DN*DW-1:0] obs, input logic [DN*DW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: sort the values, sum the middle ranks, apply the Q16 rounded mean rule
    function automatic void model(input logic [DN*DW-1:0] w, output logic [SW-1:0] es, output logic [DW-1:0] em);
        int    q[$];
        longint s;
        longint rc;
        s = 0;
        for (int k = 0; k < DN; k++) q.push_back(int'(w[k*DW +: DW]));
        q.sort();
        for (int r = ALPHA; r < DN - ALPHA; r++) s += q[r];
        rc = (65536 + NK / 2) / NK;
        es = SW'(s);
        em = DW'((s * rc + 32768) >> 16);
    endfunction

    // Sorter model: finish pulse three cycles after start, rank map updated the cycle after
    initial begin
        int pend;
        bit upd;
        int rank;
        logic [DW-1:0] v [DN];
        pend = 0;
        upd = 0;
        sf_model = 1'b0;
        sequence_sorted = '1;
        forever begin
            @(negedge clk);
            sf_model = 1'b0;
            if (upd) begin
                upd = 0;
                for (int k = 0; k < DN; k++) v[k] = data_unsort[k*DW +: DW];
                for (int k = 0; k < DN; k++) begin
                    rank = 0;
                    for (int j = 0; j < DN; j++)
                        if (v[j] < v[k] || (v[j] == v[k] && j < k)) rank++;
                    sequence_sorted[rank*DW_SEQ +: DW_SEQ] = DW_SEQ'(k);
                end
            end
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    sf_model = 1'b1;
                    upd = 1;
                end
            end else if (sort_sig && sorter_en) begin
                pend = 3;
            end
        end
    end

    // One window through the controller; hold = cycles out_ready is kept low after out_valid
    task automatic run_one(input string nm, input logic [DN*DW-1:0] w, input int hold,
                           input bit chk_lat, input bit keep_valid);
        int t0, rel, n_sort, first_ov, hs;
        logic [SW-1:0] es;
        logic [DW-1:0] em;
        model(w, es, em);
        in_window = w;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
        check({nm, "_accept_ready"}, in_ready, 1);
        t0 = cyc;
        last_acc = cyc;
        @(negedge clk);
        if (!keep_valid) in_valid = 1'b0;
        check({nm, "_data_unsort"}, data_unsort, w);
        n_sort = 0;
        first_ov = -1;
        hs = 0;
        for (int i = 0; i < 80; i++) begin
            rel = cyc - t0;
            if (sort_sig) begin
                n_sort++;
                if (chk_lat) check({nm, "_sort_sig_cycle"}, rel, 1);
            end
            if (out_valid) begin
                if (first_ov < 0) begin
                    first_ov = rel;
                    if (chk_lat) check({nm, "_out_valid_latency"}, rel, 6 + NK);
                    check({nm, "_out_sum"}, out_sum, es);
                    check({nm, "_out_mean"}, out_mean, em);
                end else begin
                    check({nm, "_held_sum"}, out_sum, es);
                    check({nm, "_held_mean"}, out_mean, em);
                    check({nm, "_held_in_ready"}, in_ready, 0);
                end
                if (rel - first_ov >= hold) out_ready = 1'b1;
                if (out_ready) begin
                    hs++;
                    last_hs = cyc;
                    break;
                end
            end
            @(negedge clk);
        end
        check({nm, "_handshake"}, hs, 1);
        check({nm, "_sort_pulses"}, n_sort, 1);
        if (!keep_valid) begin
            @(negedge clk);
            check({nm, "_after_hs"}, {out_valid, busy, in_ready}, 3'b001);
        end
    endtask

    initial begin
        logic [DN*DW-1:0] w_flat, w_ramp, w_rnd, w_rnd2;
        int rel, idle_rel, ov_seen;

        rst = 1'b1;
        in_valid = 1'b0;
        in_window = '0;
        out_ready = 1'b0;
        sf_stale = 1'b0;
        sorter_en = 1'b1;
        last_hs = 0;
        last_acc = 0;
        repeat (3) @(negedge clk);
        check("reset_ctrl", {in_ready, out_valid, sort_sig, busy, timeout_err}, 5'b10000);
        check("reset_sum", out_sum, 0);
        check("reset_mean", out_mean, 0);
        check("reset_data_unsort", data_unsort, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int k = 0; k < DN; k++) begin
            w_flat[k*DW +: DW] = DW'(100);
            w_ramp[k*DW +: DW] = DW'(10 * k);
        end
        run_one("flat100", w_flat, 0, 1, 0);
        check("flat100_sum_const", out_sum, 1700);
        check("flat100_mean_const", out_mean, 100);
        run_one("ramp", w_ramp, 0, 1, 0);
        check("ramp_sum_const", out_sum, 2040);
        check("ramp_mean_const", out_mean, 120);
        run_one("ramp_hold", w_ramp, 10, 0, 0);

        // Random windows: wide range, then narrow range for many ties, then all-max
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < DN; k++)
                w_rnd[k*DW +: DW] = (t % 2 == 0) ? DW'($urandom_range(0, 255)) : DW'($urandom_range(0, 3));
            run_one("random", w_rnd, $urandom_range(0, 3), 0, 0);
        end
        w_rnd = '1;
        run_one("all_max", w_rnd, 0, 0, 0);

        // Sorter never answers: bounded wait ends in timeout
        sorter_en = 1'b0;
        in_window = w_ramp;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
        rel = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        idle_rel = -1;
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_valid) ov_seen++;
            if (!busy) begin
                idle_rel = cyc - rel;
                break;
            end
            if (cyc - rel == 16) check("timeout_not_early", timeout_err, 0);
            @(negedge clk);
        end
        check("timeout_idle_cycle", idle_rel, 2 + TIMEOUT);
        check("timeout_err_set", timeout_err, 1);
        check("timeout_no_out_valid", ov_seen, 0);
        sorter_en = 1'b1;
        run_one("after_timeout", w_ramp, 0, 0, 0);
        check("timeout_err_sticky", timeout_err, 1);

        // Reset while accumulating, then a stale finish pulse while idle
        in_window = w_ramp;
        in_valid = 1'b1;
        for (int i = 0; i < 60 && !in_ready; i++) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("mid_acc_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_ctrl", {in_ready, out_valid, sort_sig, busy, timeout_err}, 5'b10000);
        check("mid_rst_sum", out_sum, 0);
        check("mid_rst_data", data_unsort, 0);
        sf_stale = 1'b1;
        @(negedge clk);
        sf_stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("stale_finish_quiet", {busy, sort_sig, out_valid}, 3'b000);
            @(negedge clk);
        end
        run_one("after_mid_rst", w_ramp, 0, 0, 0);

        // Back-to-back windows with in_valid held high
        for (int k = 0; k < DN; k++) begin
            w_rnd[k*DW +: DW]  = DW'($urandom_range(0, 255));
            w_rnd2[k*DW +: DW] = DW'($urandom_range(0, 255));
        end
        run_one("b2b_first", w_rnd, 0, 0, 1);
        rel = last_hs;
        run_one("b2b_second", w_rnd2, 0, 0, 0);
        check("b2b_accept_cycle", last_acc, rel + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
